hex_keypad_encoder: RTL and testbench
=====================================

// Module: hex_keypad_encoder
// PURPOSE
// - Scans a 4x4 hex keypad: drives rows active-low one at a time, reads active-low columns.
// - Debounces the result and encodes the pressed key into a 4-bit hex code 0x0-0xF.
// - Input-side counterpart of the seven-segment driver path: key_code feeds the 4-bit digit input
//   of the display.
// - Delivers one code per debounced key press over a valid/ack handshake.
// PARAMETERS
// - SCAN_DIV        1000  clocks each row is driven; legal range >= 3 (covers 2-flop sync latency)
// - DEBOUNCE_SCANS  4     consecutive identical full scans needed to accept a press or a release; >= 1
// PORTS
// - clk       in   1  single clock, rising edge
// - rst_n     in   1  asynchronous, active-low reset
// - enable    in   1  1 = scan; 0 = rows released (all 1), scan/FSM held in reset state
// - col_in    in   4  keypad columns, active-low, externally pulled up, asynchronous to clk
// - row_out   out  4  keypad rows, active-low one-hot
// - key_code  out  4  encoded key = {row[1:0], col[1:0]}; stable while key_valid=1
// - key_valid out  1  new key available; held until acknowledged
// - key_ack   in   1  consumer accepts key_code on any clk edge where key_valid=1
// - key_held  out  1  1 while a reported key is still physically pressed
// - overrun   out  1  sticky: press lost while key_valid pending (tied 0 without macro)
// BEHAVIOUR
// - Reset values: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0; FSM=IDLE; counters=0.
// - col_in passes a 2-flop synchronizer before any use.
// - Scan timing:
//   - Row pointer r (0..3) advances every SCAN_DIV clocks and wraps 3->0.
//   - row_out = ~(4'b1 << r).
//   - Synced columns are sampled on the last clock of each row period.
//   - End of scan = last clock of row 3.
// - Scan result: hit=1 if any sampled column was low during the scan.
//   - code = lowest {r,c} among all hits (priority encode, lowest index wins).
// - FSM, evaluated only at end of scan; cnt counts scans:
//   - IDLE: hit -> DEBOUNCE with cand=code, cnt=1.
//   - DEBOUNCE:
//     - no hit -> IDLE.
//     - hit with code != cand -> cand=code, cnt=1.
//     - hit with code == cand -> cnt++; when cnt reaches DEBOUNCE_SCANS -> PRESSED and report cand.
//     - DEBOUNCE_SCANS=1 goes IDLE -> PRESSED directly.
//   - PRESSED: no hit -> RELEASE_DB with cnt=1; any hit -> stay.
//   - RELEASE_DB: any hit -> PRESSED; no hit -> cnt++; when cnt reaches DEBOUNCE_SCANS -> IDLE.
// - key_held = 1 in PRESSED and RELEASE_DB.
// - Report:
//   - On the clock after the accepting end-of-scan, key_code=cand and key_valid=1.
//   - Total latency from first stable sample = DEBOUNCE_SCANS scans + 1 clock.
// - Handshake:
//   - key_valid clears on the clock after a key_ack edge.
//   - key_ack while key_valid=0 is ignored.
//   - Report while key_valid=1 and no ack: new press dropped; key_code keeps the old value.
//   - Report and ack on the same edge: new code loads and key_valid stays 1; not an overrun.
// - enable=0:
//   - row_out=4'hF; scan counters, row pointer, FSM and cnt return to reset values; key_held=0.
//   - key_valid/key_code are kept until acked.
// - rst_n low at any time, including mid-scan or mid-debounce: all outputs take reset values immediately.
// CONFIGURATION
// - KEYPAD_OVERRUN_EN defined: a dropped press sets overrun=1.
//   - overrun stays 1 until the next key_ack edge clears it, together with key_valid.
// - KEYPAD_OVERRUN_EN undefined: overrun tied 0; drop behaviour otherwise identical.
// STRUCTURE
// - keypad_pkg:
//   - typedef logic [3:0] key_code_t
//   - enum kp_state_t {IDLE, DEBOUNCE, PRESSED, RELEASE_DB}
//   - localparam NUM_ROWS=4, NUM_COLS=4
// - Sub-module keypad_col_sync: 4-bit 2-flop synchronizer, async active-low reset to 4'hF.
// - Row/scan timer, priority encoder and FSM live in this module.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3, 16-clock scan)
// - Reset: rst_n=0 -> row_out=4'b1110, key_valid=0, key_held=0, overrun=0; release -> rows cycle 1110,1101,1011,0111.
// - Press row2/col1 held 5 scans:
//   - key_valid rises 1 clk after 3rd scan end, key_code=4'h9, key_held=1.
//   - ack -> key_valid=0.
//   - Release -> key_held=0 after 3 empty scans.
// - Bounce (key present on alternate scans for 8 scans) -> key_valid never asserts.
// - Keys 0x5 and 0xA both pressed -> key_code=4'h5.
// - 0x3 reported unacked, then 0xC pressed and debounced:
//   - key_code stays 3.
//   - overrun=1 with KEYPAD_OVERRUN_EN, 0 without.
//   - ack clears key_valid and overrun.
// - rst_n pulsed low mid-DEBOUNCE -> outputs reset same cycle; enable=0 -> row_out=4'hF, pending key_valid kept.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad encoder.
//   key_code_t    : 4-bit key code {row[1:0], col[1:0]}
//   kp_state_t    : press/release debounce FSM states
//   first_low_col : index of the lowest active-low column in a 4-bit sample
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    // Lowest column index wins when several columns are low at once.
    function automatic logic [1:0] first_low_col(input logic [NUM_COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!cols[c]) idx = 2'(c);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
// Resets to all-ones, which reads as "no column pulled low".
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   d_i   : raw column inputs
//   q_o   : synchronized column inputs
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] d_i,
    output logic [NUM_COLS-1:0] q_o
);

    logic [NUM_COLS-1:0] meta_q;
    logic [NUM_COLS-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hex_keypad_encoder.sv
// 4x4 hex keypad scanner / debouncer / encoder with a valid-ack output.
// Rows are driven low one at a time for SCAN_DIV clocks each; synchronized
// columns are sampled on the last clock of each row. A full 4-row scan yields
// (hit, lowest {row,col}); the FSM below debounces press and release over
// DEBOUNCE_SCANS identical scans and reports one code per press.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 = scanning; 0 = rows released, scan logic held at reset
//   col_in     : keypad columns, active-low, asynchronous
//   row_out    : keypad rows, active-low one-hot
//   key_code   : reported key code, stable while key_valid=1
//   key_valid  : report pending until key_ack
//   key_ack    : consumer accept, honoured only while key_valid=1
//   key_held   : reported key still physically down
//   overrun    : sticky flag for a press dropped while a report was pending
//
// Build option: KEYPAD_OVERRUN_EN enables the overrun flag; without it the
// flag is tied low and dropped presses are silently discarded.
//
// state      | meaning
// IDLE       | no key down, waiting for a hit
// DEBOUNCE   | candidate seen, counting identical scans
// PRESSED    | key reported (or dropped), still down
// RELEASE_DB | key appears released, counting empty scans
module hex_keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output key_code_t           key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_COLS-1:0] col_sync;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic             hit_acc_q, hit_acc_d;
    key_code_t        code_acc_q, code_acc_d;
    kp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_code_t        cand_q, cand_d;
    key_code_t        key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic      row_last;
    logic      scan_end;
    logic      row_hit;
    key_code_t row_code;
    logic      scan_hit;
    key_code_t scan_code;
    logic      report;
    logic      report_drop;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (col_in),
        .q_o   (col_sync)
    );

    // Scan result for the current row folded into the running scan result.
    // Rows come in ascending order, so the first hit of a scan is the lowest code.
    always_comb begin
        row_last  = (div_q == DIV_LAST);
        scan_end  = row_last && (row_q == 2'(NUM_ROWS - 1));
        row_hit   = ~&col_sync;
        row_code  = {row_q, first_low_col(col_sync)};
        scan_hit  = hit_acc_q | row_hit;
        scan_code = hit_acc_q ? code_acc_q : row_code;
    end

    always_comb begin
        div_d      = div_q;
        row_d      = row_q;
        hit_acc_d  = hit_acc_q;
        code_acc_d = code_acc_q;
        if (!enable) begin
            div_d      = '0;
            row_d      = '0;
            hit_acc_d  = 1'b0;
            code_acc_d = '0;
        end else if (row_last) begin
            div_d = '0;
            row_d = row_q + 2'd1;
            if (scan_end) begin
                hit_acc_d  = 1'b0;
                code_acc_d = '0;
            end else begin
                hit_acc_d  = scan_hit;
                code_acc_d = scan_code;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        report  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            cand_d  = '0;
        end else if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        cand_d = scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            report  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!scan_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        report  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!scan_hit) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (scan_hit) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A same-edge ack frees the output slot, so a report on that edge loads.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        report_drop = 1'b0;
        if (key_ack && key_valid_q) key_valid_d = 1'b0;
        if (report) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = scan_code;
                key_valid_d = 1'b1;
            end else begin
                report_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            row_q       <= '0;
            hit_acc_q   <= 1'b0;
            code_acc_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            hit_acc_q   <= hit_acc_d;
            code_acc_q  <= code_acc_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

`ifdef KEYPAD_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (key_ack && key_valid_q) overrun_d = 1'b0;
        if (report_drop) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    logic unused_drop;
    assign unused_drop = report_drop;
    assign overrun     = 1'b0;
`endif

    assign row_out   = enable ? ~(4'b0001 << row_q) : 4'hF;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = enable && ((state_q == PRESSED) || (state_q == RELEASE_DB));

endmodule

// File: tb/tb_hex_keypad_encoder.sv
module tb_hex_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       key_ack = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    // Physical keypad: bit (r*4+c) set means key {r,c} is held down.
    logic [15:0] keys = '0;

    int checks   = 0;
    int failures = 0;

    // Reference model: debounce as run lengths of identical scan results.
    bit         m_valid;
    bit         m_held;
    bit         m_ovr;
    logic [3:0] m_code;
    logic [3:0] m_cand;
    int         m_run;
    int         m_rel;

    hex_keypad_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_in[c] = 1'b1;
            for (int r = 0; r < 4; r++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] m);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) v = 4'(i);
        return v;
    endfunction

    function automatic logic exp_ovr();
`ifdef KEYPAD_OVERRUN_EN
        return m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_held = 0; m_ovr = 0;
        m_code = 4'h0; m_cand = 4'h0; m_run = 0; m_rel = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"},   key_valid, m_valid);
        check({tag, "_code"},    key_code,  m_code);
        check({tag, "_held"},    key_held,  m_held);
        check({tag, "_overrun"}, overrun,   exp_ovr());
    endtask

    // One full 16-clock scan with a fixed key mask.
    // ack: 0 none, 1 ack on the first clock of the scan, 2 ack on the scan-end clock.
    task automatic scan(input logic [15:0] mask, input int ack, input string tag);
        bit         hit;
        bit         report;
        logic [3:0] code;
        keys = mask;
        if (ack == 1) begin
            key_ack = 1'b1;
            @(posedge clk);
            #1 key_ack = 1'b0;
            repeat (15) @(posedge clk);
        end else if (ack == 2) begin
            repeat (15) @(posedge clk);
            #1 key_ack = 1'b1;
            @(posedge clk);
        end else begin
            repeat (16) @(posedge clk);
        end
        #1 key_ack = 1'b0;

        if (ack == 1 && m_valid) begin m_valid = 0; m_ovr = 0; end
        hit    = (mask != 16'h0);
        code   = lowest(mask);
        report = 0;
        if (!m_held) begin
            if (!hit)                            m_run = 0;
            else if (m_run > 0 && code == m_cand) m_run++;
            else begin m_cand = code; m_run = 1; end
            if (m_run == DS) begin
                m_held = 1; m_run = 0; m_rel = 0; report = 1;
            end
        end else begin
            m_rel = hit ? 0 : m_rel + 1;
            if (m_rel == DS) begin m_held = 0; m_rel = 0; end
        end
        if (ack == 2 && m_valid) begin m_valid = 0; m_ovr = 0; end
        if (report) begin
            if (!m_valid) begin m_valid = 1; m_code = code; end
            else m_ovr = 1;
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] exp_row;
        logic [15:0] mask;
        int seg_len;
        int kind;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_row",     row_out,   4'b1110);
        check("rst_valid",   key_valid, 1'b0);
        check("rst_held",    key_held,  1'b0);
        check("rst_overrun", overrun,   1'b0);
        check("rst_code",    key_code,  4'h0);

        @(negedge clk) rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_row = ~(4'b0001 << r);
            check("row_cycle", row_out, exp_row);
            repeat (4) @(posedge clk);
            #1;
        end

        // Key 9 (row 2, col 1): report after the third scan, ack, then release.
        for (int i = 0; i < 3; i++) scan(16'h1 << 9, 0, "press9");
        check("press9_code_fixed", key_code, 4'h9);
        check("press9_valid_fixed", key_valid, 1'b1);
        scan(16'h1 << 9, 1, "press9_ack");
        check("press9_acked", key_valid, 1'b0);
        scan(16'h1 << 9, 0, "press9_hold");
        for (int i = 0; i < 3; i++) scan(16'h0, 0, "release9");
        check("release9_held_fixed", key_held, 1'b0);

        // Bouncing contact on alternate scans never reports.
        for (int i = 0; i < 8; i++) scan((i % 2 == 0) ? (16'h1 << 9) : 16'h0, 0, "bounce");
        check("bounce_valid_fixed", key_valid, 1'b0);

        // Keys 5 and A together: lowest index wins.
        for (int i = 0; i < 3; i++) scan((16'h1 << 5) | (16'h1 << 10), 0, "dual");
        check("dual_code_fixed", key_code, 4'h5);
        scan(16'h0, 1, "dual_ack");
        for (int i = 0; i < 2; i++) scan(16'h0, 0, "dual_rel");

        // Key 3 reported and left pending, then key C dropped.
        for (int i = 0; i < 3; i++) scan(16'h1 << 3, 0, "key3");
        for (int i = 0; i < 3; i++) scan(16'h0, 0, "key3_rel");
        for (int i = 0; i < 3; i++) scan(16'h1 << 12, 0, "keyC_drop");
        check("drop_code_fixed", key_code, 4'h3);
        scan(16'h0, 1, "drop_ack");
        check("drop_ack_overrun", overrun, 1'b0);
        for (int i = 0; i < 2; i++) scan(16'h0, 0, "drop_rel");

        // Report and ack landing on the same edge.
        for (int i = 0; i < 3; i++) scan(16'h1 << 6, 0, "key6");
        for (int i = 0; i < 3; i++) scan(16'h0, 0, "key6_rel");
        for (int i = 0; i < 2; i++) scan(16'h1 << 14, 0, "keyE");
        scan(16'h1 << 14, 2, "keyE_sameedge");
        check("sameedge_code_fixed", key_code, 4'hE);
        for (int i = 0; i < 3; i++) scan(16'h0, 0, "keyE_rel");

        // Reset pulse in the middle of a debounce with a report pending.
        scan(16'h1 << 7, 0, "mid_db");
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_row",     row_out,   4'b1110);
        check("midrst_valid",   key_valid, 1'b0);
        check("midrst_code",    key_code,  4'h0);
        check("midrst_held",    key_held,  1'b0);
        check("midrst_overrun", overrun,   1'b0);
        model_reset();
        keys = 16'h0;
        @(negedge clk) rst_n = 1'b1;

        // enable=0 with a report pending.
        for (int i = 0; i < 3; i++) scan(16'h1 << 2, 0, "key2");
        enable = 1'b0;
        #1;
        check("dis_row",  row_out,  4'hF);
        check("dis_held", key_held, 1'b0);
        @(posedge clk);
        #1;
        check("dis_valid", key_valid, 1'b1);
        check("dis_code",  key_code,  4'h2);
        keys = 16'h0;
        @(negedge clk) enable = 1'b1;
        m_held = 0; m_run = 0; m_rel = 0;
        scan(16'h0, 1, "dis_ack");

        // Randomized segments of repeated masks with random acks.
        for (int s = 0; s < 14; s++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)      mask = 16'h0;
            else if (kind == 1) mask = 16'h1 << $urandom_range(0, 15);
            else                mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            seg_len = int'($urandom_range(1, 5));
            for (int k = 0; k < seg_len; k++) scan(mask, int'($urandom_range(0, 2)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
